// File: rtl/canvas_reader.sv
// canvas_reader: raster-order readback of the 24-bit canvas from frame memory.
// Fixed-latency reads, credit-limited so the output skid FIFO never overflows.
module canvas_reader #(
    parameter int IMG_W      = 1024,
    parameter int IMG_H      = 768,
    parameter int ADDR_W     = 20,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_mem_rd,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [23:0]       i_mem_rdata,
    output logic              o_pix_valid,
    input  logic              i_pix_ready,
    output logic [23:0]       o_pix_data,
    output logic              o_pix_sof,
    output logic              o_pix_eol
);
    localparam int NPIX = IMG_W * IMG_H;
    localparam int XW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int DW   = 26;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NPIX - 1);
    localparam logic [XW-1:0]     XLAST = XW'(IMG_W - 1);
    localparam logic [CW:0]       DEPTH = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [ADDR_W-1:0]  r_addr;
    logic [XW-1:0]      r_x;
    logic               r_sof;
    logic               r_mem_rd;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic               r_iss_sof;
    logic               r_iss_eol;
    logic [RD_LAT-1:0]  r_vld;
    logic [RD_LAT-1:0]  r_tsof;
    logic [RD_LAT-1:0]  r_teol;
    logic [DW-1:0]      r_fdata [FIFO_DEPTH];
    logic [PW-1:0]      r_wp;
    logic [PW-1:0]      r_rp;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      r_infl;

    logic               w_ret;
    logic               w_fvalid;
    logic               w_pop;
    logic               w_issue;
    logic               w_last;
    logic [CW:0]        w_used;
    logic [DW-1:0]      w_head;

    // Credits freed by this cycle's pop are reusable at once.
    assign w_ret    = r_vld[RD_LAT-1];
    assign w_fvalid = (r_cnt != '0);
    assign w_pop    = w_fvalid & i_pix_ready;
    assign w_used   = {1'b0, r_cnt} + {1'b0, r_infl}
                    - {{CW{1'b0}}, w_pop};
    assign w_issue  = (r_state == S_READ) && (w_used < DEPTH);
    assign w_last   = (r_addr == LAST);
    assign w_head   = r_fdata[r_rp];

    assign o_mem_rd   = r_mem_rd;
    assign o_mem_addr = r_mem_addr;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_READ;
            S_READ:  if (w_issue && w_last) w_next = S_DRAIN;
            S_DRAIN: if (w_used == '0) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy      = (r_state != S_IDLE);
        o_done      = (r_state == S_DONE);
        o_pix_valid = w_fvalid;
        o_pix_data  = '0;
        o_pix_sof   = 1'b0;
        o_pix_eol   = 1'b0;
        if (w_fvalid) {o_pix_data, o_pix_sof, o_pix_eol} = w_head;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_addr     <= '0;
            r_x        <= '0;
            r_sof      <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= '0;
            r_iss_sof  <= 1'b0;
            r_iss_eol  <= 1'b0;
        end else begin
            r_mem_rd <= w_issue;
            if (r_state == S_IDLE) begin
                r_addr <= '0;
                r_x    <= '0;
                r_sof  <= 1'b1;
            end else if (w_issue) begin
                r_addr <= r_addr + 1'b1;
                r_x    <= (r_x == XLAST) ? '0 : r_x + 1'b1;
                r_sof  <= 1'b0;
            end
            if (w_issue) begin
                r_mem_addr <= r_addr;
                r_iss_sof  <= r_sof;
                r_iss_eol  <= (r_x == XLAST);
            end
        end
    end

    // Tags ride alongside the read so returns need no address decode.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_vld  <= '0;
            r_tsof <= '0;
            r_teol <= '0;
        end else begin
            r_vld[0]  <= r_mem_rd;
            r_tsof[0] <= r_iss_sof;
            r_teol[0] <= r_iss_eol;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_tsof[i] <= r_tsof[i-1];
                r_teol[i] <= r_teol[i-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_cnt  <= '0;
            r_infl <= '0;
        end else begin
            if (w_ret) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_cnt  <= r_cnt + CW'(w_ret) - CW'(w_pop);
            r_infl <= r_infl + CW'(w_issue) - CW'(w_ret);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_ret)
            r_fdata[r_wp] <= {i_mem_rdata, r_tsof[RD_LAT-1], r_teol[RD_LAT-1]};
    end
endmodule
